// File: rtl/ro_meas_pkg.sv
// Shared types and default parameters for the ring-oscillator measurement controller.
package ro_meas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } ro_meas_state_t;

    localparam int unsigned RO_GATE_W_DEF     = 16;
    localparam int unsigned RO_CNT_W_DEF      = 16;
    localparam int unsigned RO_SETTLE_CYC_DEF = 8;

endpackage

// File: rtl/ro_sync.sv
// Two-flop synchronizer bringing the free-running oscillator output into the clk domain.
module ro_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Double-register the asynchronous input to resolve metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement sequencer: enable, settle, count synchronized rising
// edges over a programmable gate window, then publish a saturating count with a done pulse.
module ro_meas_ctrl
    import ro_meas_pkg::*;
#(
    parameter int unsigned GATE_W     = RO_GATE_W_DEF,
    parameter int unsigned CNT_W      = RO_CNT_W_DEF,
    parameter int unsigned SETTLE_CYC = RO_SETTLE_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              ro_in,
    output logic              ro_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              ovf
);

    localparam int unsigned      SET_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    ro_meas_state_t    state_q;
    logic [SET_W-1:0]  settle_q;
    logic [GATE_W-1:0] gate_q;
    logic [CNT_W-1:0]  run_q;
    logic              run_ovf_q;
    logic              ro_en_q;
    logic              busy_q;
    logic              done_q;
    logic [CNT_W-1:0]  count_q;
    logic              ovf_q;

    logic              ro_sync_s;
    logic              ro_hist_q;
    logic              ro_rise_s;
    logic [CNT_W-1:0]  run_d;
    logic              run_ovf_d;

    ro_sync u_ro_sync (
        .clk (clk),
        .rst (rst),
        .d_i (ro_in),
        .q_o (ro_sync_s)
    );

    // History flop for rising-edge detection on the synchronized oscillator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ro_hist_q <= 1'b0;
        end else begin
            ro_hist_q <= ro_sync_s;
        end
    end

    assign ro_rise_s = ro_sync_s & ~ro_hist_q;

    // Saturating next value of the running edge count; ovf latches once the ceiling is hit.
    always_comb begin
        run_d = run_q;
        if (ro_rise_s && (run_q != CNT_MAX)) begin
            run_d = run_q + CNT_W'(1);
        end else begin
            run_d = run_q;
        end
        run_ovf_d = run_ovf_q | (run_d == CNT_MAX);
    end

    // Measurement FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            settle_q  <= {SET_W{1'b0}};
            gate_q    <= {GATE_W{1'b0}};
            run_q     <= {CNT_W{1'b0}};
            run_ovf_q <= 1'b0;
            ro_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= {CNT_W{1'b0}};
            ovf_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        run_q     <= {CNT_W{1'b0}};
                        run_ovf_q <= 1'b0;
                        if (gate_cycles != {GATE_W{1'b0}}) begin
                            gate_q   <= gate_cycles;
                            settle_q <= SET_LOAD;
                            ro_en_q  <= 1'b1;
                            busy_q   <= 1'b1;
                            state_q  <= ST_SETTLE;
                        end else begin
                            count_q <= {CNT_W{1'b0}};
                            ovf_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        ro_en_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (settle_q == {SET_W{1'b0}}) begin
                        state_q <= ST_MEASURE;
                    end else begin
                        settle_q <= settle_q - SET_W'(1);
                    end
                end
                ST_MEASURE: begin
                    if (abort) begin
                        ro_en_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        run_q     <= run_d;
                        run_ovf_q <= run_ovf_d;
                        gate_q    <= gate_q - GATE_W'(1);
                        // The final gate cycle's edge is folded straight into the published result.
                        if (gate_q == GATE_W'(1)) begin
                            ro_en_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            count_q <= run_d;
                            ovf_q   <= run_ovf_d;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    ro_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ro_en = ro_en_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Directed self-checking bench for ro_meas_ctrl: a 16-bit and a 4-bit counter instance share stimulus.
module tb_ro_meas_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] gate_cycles;
    logic        ro_in;
    logic        ro_gen;
    logic        ro_man;
    int          ro_half;

    logic        ro_en, busy, done, ovf;
    logic [15:0] count;
    logic        ro_en4, busy4, done4, ovf4;
    logic [3:0]  count4;

    int checks;
    int failures;
    int done_cnt;
    logic ro_en_seen;

    ro_meas_ctrl #(.GATE_W(16), .CNT_W(16), .SETTLE_CYC(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .gate_cycles(gate_cycles), .ro_in(ro_in),
        .ro_en(ro_en), .busy(busy), .done(done), .count(count), .ovf(ovf)
    );

    ro_meas_ctrl #(.GATE_W(16), .CNT_W(4), .SETTLE_CYC(8)) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .gate_cycles(gate_cycles), .ro_in(ro_in),
        .ro_en(ro_en4), .busy(busy4), .done(done4), .count(count4), .ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ro_in = (ro_half != 0) ? ro_gen : ro_man;

    // Free-running oscillator model: toggles every ro_half clk cycles.
    initial begin
        int cnt;
        cnt = 0;
        ro_gen = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ro_half != 0) begin
                cnt++;
                if (cnt >= ro_half) begin
                    cnt = 0;
                    ro_gen = ~ro_gen;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (ro_en) ro_en_seen = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one start and wait for done; n is the cycle offset of done from the start cycle.
    task automatic run_meas(input logic [15:0] g, output int n, output logic b1, output logic e1);
        gate_cycles = g;
        start = 1'b1;
        step();
        b1 = busy;
        e1 = ro_en;
        start = 1'b0;
        n = 1;
        while (!done && n < 2000) begin
            step();
            n++;
        end
        check_eq("done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int   n;
        logic b1, e1;
        checks = 0;
        failures = 0;
        done_cnt = 0;
        ro_en_seen = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        gate_cycles = 16'd0;
        ro_man = 1'b0;
        ro_half = 0;
        step();
        step();
        check_eq("rst_ro_en", {31'd0, ro_en}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_count", {16'd0, count}, 32'd0);
        check_eq("rst_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;
        step();

        // Zero-length gate window.
        ro_en_seen = 1'b0;
        run_meas(16'd0, n, b1, e1);
        check_eq("g0_latency", n, 32'd1);
        check_eq("g0_busy", {31'd0, b1}, 32'd0);
        check_eq("g0_count", {16'd0, count}, 32'd0);
        check_eq("g0_ovf", {31'd0, ovf}, 32'd0);
        step();
        check_eq("g0_ro_en_never", {31'd0, ro_en_seen}, 32'd0);

        // G=100, rising edge every 8 clk.
        ro_half = 4;
        run_meas(16'd100, n, b1, e1);
        check_eq("g100_busy_t1", {31'd0, b1}, 32'd1);
        check_eq("g100_ro_en_t1", {31'd0, e1}, 32'd1);
        check_eq("g100_latency", n, 32'd109);
        check_eq("g100_done_ro_en", {31'd0, ro_en}, 32'd0);
        check_eq("g100_done_busy", {31'd0, busy}, 32'd0);
        check_eq("g100_count_range", {31'd0, (count >= 16'd12) && (count <= 16'd13)}, 32'd1);
        check_eq("g100_ovf", {31'd0, ovf}, 32'd0);
        step();

        // Saturation on the 4-bit instance, rising every 4 clk.
        ro_half = 2;
        run_meas(16'd200, n, b1, e1);
        check_eq("sat_count4", {28'd0, count4}, 32'd15);
        check_eq("sat_ovf4", {31'd0, ovf4}, 32'd1);
        check_eq("sat_count16_range", {31'd0, (count >= 16'd49) && (count <= 16'd51)}, 32'd1);
        check_eq("sat_ovf16", {31'd0, ovf}, 32'd0);
        step();

        // Slow oscillator clears ovf.
        ro_half = 20;
        run_meas(16'd100, n, b1, e1);
        check_eq("slow_ovf4", {31'd0, ovf4}, 32'd0);
        check_eq("slow_count4_range", {31'd0, (count4 >= 4'd2) && (count4 <= 4'd3)}, 32'd1);
        step();

        // Exactly 42 hand-driven pulses inside MEASURE.
        ro_half = 0;
        ro_man = 1'b0;
        gate_cycles = 16'd200;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        for (int i = 0; i < 42; i++) begin
            ro_man = 1'b1;
            step();
            step();
            ro_man = 1'b0;
            step();
            step();
        end
        n = 0;
        while (!done && n < 500) begin
            step();
            n++;
        end
        check_eq("man42_done", {31'd0, done}, 32'd1);
        check_eq("man42_count", {16'd0, count}, 32'd42);
        check_eq("man42_ovf", {31'd0, ovf}, 32'd0);
        step();

        // Abort 5 cycles into MEASURE.
        done_cnt = 0;
        ro_half = 4;
        gate_cycles = 16'd200;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 12; i++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("abort_ro_en", {31'd0, ro_en}, 32'd0);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 250; i++) step();
        check_eq("abort_no_done", done_cnt, 32'd0);
        check_eq("abort_count_kept", {16'd0, count}, 32'd42);

        // Start while busy ignored; start+abort in IDLE ignored.
        done_cnt = 0;
        gate_cycles = 16'd20;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 40; i++) step();
        check_eq("busy_start_one_done", done_cnt, 32'd1);
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check_eq("start_abort_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 40; i++) step();
        check_eq("start_abort_no_done", done_cnt, 32'd1);

        // Asynchronous reset mid-MEASURE, then a clean rerun.
        gate_cycles = 16'd100;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 15; i++) step();
        rst = 1'b1;
        #1;
        check_eq("midrst_ro_en", {31'd0, ro_en}, 32'd0);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_done", {31'd0, done}, 32'd0);
        check_eq("midrst_count", {16'd0, count}, 32'd0);
        step();
        rst = 1'b0;
        ro_half = 0;
        ro_man = 1'b0;
        step();
        run_meas(16'd10, n, b1, e1);
        check_eq("post_rst_latency", n, 32'd19);
        check_eq("post_rst_count", {16'd0, count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
